// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes: multi-lane serial CRC engine for the SD host path.
//
// Each of LANES lanes runs an independent MSB-first Galois LFSR of WIDTH
// bits over its data bit, qualified by bit_en on the system clock. On
// out_start the lane registers are snapshotted and shifted out MSB first
// over exactly WIDTH cycles. The lane registers then reload to INIT.
// crc_zero gives the receive check: feed payload plus received CRC, and a
// zero remainder means a good frame.
//
// State table:
//   ACCUM | absorbing bits when bit_en=1; out_start snapshots and leaves
//   SHIFT | presenting one CRC bit per lane per cycle, WIDTH cycles total
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clear      reload every lane register to INIT (aborts a shift-out)
//   bit_en     bit_in is valid this cycle
//   bit_in     one data bit per lane, lane i uses bit_in[i]
//   out_start  begin serial shift-out of the current CRCs
//   crc        lane registers, lane i at [i*WIDTH +: WIDTH]
//   crc_zero   per-lane register equals zero (ACCUM only)
//   out_bit    serial CRC bit per lane, MSB first
//   out_valid  out_bit is valid this cycle
//   out_last   final bit (bit 0) of the shift-out
//   busy       engine is in SHIFT
module sd_crc_lanes #(
    parameter int               LANES = 4,
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h1021,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   bit_en,
    input  logic [LANES-1:0]       bit_in,
    input  logic                   out_start,
    output logic [LANES*WIDTH-1:0] crc,
    output logic [LANES-1:0]       crc_zero,
    output logic [LANES-1:0]       out_bit,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic {ACCUM, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] lane_q  [LANES];
    logic [WIDTH-1:0] shift_q [LANES];
    logic [WIDTH-1:0] lane_nxt[LANES];
    logic [WIDTH-1:0] snap    [LANES];

    // One Galois LFSR step; bit 0 always takes the feedback term.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] r,
                                                  input logic             b);
        logic             inv;
        logic [WIDTH-1:0] n;
        inv  = b ^ r[WIDTH-1];
        n    = {r[WIDTH-2:0], 1'b0} ^ (inv ? POLY : '0);
        n[0] = inv;
        return n;
    endfunction

    // The snapshot includes a bit arriving on the same cycle as out_start.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_nxt[i] = crc_step(lane_q[i], bit_in[i]);
            snap[i]     = bit_en ? lane_nxt[i] : lane_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= ACCUM;
            cnt       <= '0;
            out_bit   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i]  <= INIT;
                shift_q[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (bit_en) begin
                        for (int i = 0; i < LANES; i++)
                            lane_q[i] <= lane_nxt[i];
                    end
                    if (out_start) begin
                        // First output bit is presented straight from the
                        // snapshot so it appears the cycle after out_start.
                        for (int i = 0; i < LANES; i++) begin
                            out_bit[i] <= snap[i][WIDTH-1];
                            shift_q[i] <= {snap[i][WIDTH-2:0], 1'b0};
                        end
                        cnt       <= CNT_TOP;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state     <= ACCUM;
                        out_bit   <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        for (int i = 0; i < LANES; i++)
                            lane_q[i] <= INIT;
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            out_bit[i] <= shift_q[i][WIDTH-1];
                            shift_q[i] <= {shift_q[i][WIDTH-2:0], 1'b0};
                        end
                        cnt      <= cnt - 1'b1;
                        out_last <= (cnt == CNT_ONE);
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign crc[g*WIDTH +: WIDTH] = lane_q[g];
            assign crc_zero[g] = (state == ACCUM) && (lane_q[g] == '0);
        end
    endgenerate

endmodule

// File: doc/sd_crc_lanes.md
Name: sd_crc_lanes

Overview:
- Parametrised multi-lane serial CRC engine for the SD host path.
- One instance covers the CMD line (1 lane, CRC7) and another covers the DAT bus (4 lanes, CRC16 each, computed in parallel).
- Each lane accumulates a Galois LFSR CRC over incoming bits, serialises the result MSB-first for transmit, and flags a zero remainder on receive checks.
- Runs on the system clock with a bit-enable strobe; it does not run on a bit-rate clock.

Parameters:
- LANES, 4, number of independent data lanes (1..8).
- WIDTH, 16, CRC register width (2..32).
- POLY, 16'h1021, generator polynomial without the implicit x^WIDTH term (CRC7 uses 7'h09).
- INIT, 0, register value after reset, clear, or end of shift-out.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  reload every lane register to INIT.
- bit_en  in  1  one data bit per lane is valid this cycle.
- bit_in  in  LANES  data bit per lane; lane i uses bit_in[i].
- out_start  in  1  begin serial shift-out of the current CRCs.
- crc  out  LANES*WIDTH  current register per lane; lane i occupies [i*WIDTH +: WIDTH].
- crc_zero  out  LANES  lane register equals 0 (receive check).
- out_bit  out  LANES  serial CRC bit per lane, MSB first.
- out_valid  out  1  out_bit is valid this cycle.
- out_last  out  1  final bit (bit 0) of the shift-out.
- busy  out  1  engine is in SHIFT.

Behaviour:
- Reset value of every output:
  - crc = {LANES{INIT}}.
  - crc_zero = (INIT==0) per lane.
  - out_bit = 0, out_valid = 0, out_last = 0, busy = 0.
  - State = ACCUM.
- States: ACCUM, SHIFT.
- ACCUM, when bit_en=1, per lane:
  - inv = bit_in[i] ^ reg[WIDTH-1].
  - next reg = (reg << 1) ^ (inv ? POLY : 0), truncated to WIDTH.
  - Bit 0 receives inv.
  - The update is registered: crc reflects the bit on the cycle after bit_en.
- ACCUM, when bit_en=0: registers hold.
- ACCUM, when out_start=1:
  - Copy every lane register into a per-lane shift register.
  - Load the bit counter with WIDTH-1.
  - Go to SHIFT.
  - If bit_en is also 1 that cycle, that bit is absorbed first and the snapshot includes it.
- SHIFT, each cycle:
  - out_valid=1 and out_bit[i] = shift[i][WIDTH-1]; shift left by one; counter decrements.
  - out_last=1 when the counter is 0.
  - The cycle after out_last: return to ACCUM, lane registers reload to INIT, out_valid=0.
  - Shift-out is exactly WIDTH consecutive cycles, with the first bit on the cycle after out_start.
- SHIFT, other inputs:
  - bit_en and out_start are ignored; crc holds its snapshot value.
  - clear aborts immediately: outputs drop to their reset values next cycle and state returns to ACCUM.
- Priority: rst > clear > out_start/bit_en.
  - clear together with bit_en discards the bit; the register becomes INIT.
- crc_zero is combinational from the lane register; it is valid in ACCUM only and forced to 0 in SHIFT.
  - Receive check: feed the payload plus the received CRC bits, then crc_zero=1 means a good frame.
- A rst or clear during SHIFT truncates the frame. No partial-frame recovery.
- Lanes are fully independent; no cross-lane carry.

Test Plan:
- CRC7, LANES=1, WIDTH=7, POLY=7'h09: feed the 40 bits of 40 00 00 00 00 MSB-first -> crc=7'h4A.
- Same CRC7 configuration, further messages:
  - 51 00 00 00 00 -> crc=7'h2A.
  - 48 00 00 01 AA -> crc=7'h43.
- CRC16, LANES=4: 4096 bits of all-ones on every lane -> every lane crc=16'h7FA1.
- Same CRC16 setup, then out_start -> out_valid high for exactly 16 cycles; out_bit on each lane = 0111_1111_1010_0001; out_last on the 16th cycle; crc=0 the following cycle.
- Receive check, per lane:
  - 4096 ones followed by the 16 bits of 7FA1 -> crc_zero=1 on all lanes.
  - Flip one payload bit on lane 2 -> crc_zero=4'b1011.
- Boundary cases:
  - clear asserted on the 5th cycle of SHIFT -> out_valid=0 and busy=0 next cycle; crc=INIT.
  - bit_en held during SHIFT -> no change to the shifted bits.
  - clear together with bit_en -> crc=INIT.
